axis_frame_source: RTL and testbench

Programmable AXI-Stream frame generator: the transmitting end that drives complete frames into `axis_frame_fifo` and similar store-and-forward receivers. On a start pulse it emits `frame_count` frames of `frame_len` beats each, with an incrementing data pattern, `tlast` on each frame's final beat and an optional inter-frame gap. It honours backpressure and can mark a chosen frame bad via `tuser`, so benches and built-in self-test can exercise receiver drop and reset paths.

---
 rtl/axis_frame_source_pkg.sv | 13 +
 rtl/axis_frame_source_if.sv | 28 ++
 rtl/axis_frame_source_gap_timer.sv | 33 +++
 rtl/axis_frame_source.sv | 241 ++++++++++++++++++++++++
 tb/tb_axis_frame_source.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_frame_source_pkg.sv
// Shared definitions for the AXI-Stream frame source: FSM state encoding
// and the tuser value that marks a frame as bad.
package axis_frame_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SEND   = 2'd1;
  localparam logic [1:0] ST_GAP    = 2'd2;
  localparam logic [1:0] ST_FINISH = 2'd3;

  // Also consumed by axis_frame_fifo benches to recognise a bad frame.
  localparam logic USER_BAD_FRAME = 1'b1;

endpackage

// File: rtl/axis_frame_source_if.sv
// AXI-Stream channel between the frame source (master) and a receiver (slave).
interface axis_frame_source_if #(
  parameter int DATA_WIDTH = 8
) ();

  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic                  tuser;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    output tuser,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    input  tuser,
    output tready
  );

endinterface

// File: rtl/axis_frame_source_gap_timer.sv
// Loadable down-counter; expire pulses during the last counted cycle so the
// owner leaves its wait state after exactly load_value cycles.
module axis_frame_source_gap_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             expire
);

  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

  logic [WIDTH-1:0] count_r;

  // Count register: load has priority, otherwise count down to zero and stop.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= CNT_ZERO;
    end else if (load) begin
      count_r <= load_value;
    end else if (count_r != CNT_ZERO) begin
      count_r <= count_r - CNT_ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign expire = (count_r == CNT_ONE) && !load;

endmodule

// File: rtl/axis_frame_source.sv
// Programmable AXI-Stream frame generator with incrementing data pattern.
// Optional bad-frame tuser marking: define AXIS_FRAME_SOURCE_BAD_FRAME_EN.
module axis_frame_source
  import axis_frame_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int LEN_WIDTH   = 8,
  parameter int COUNT_WIDTH = 8,
  parameter int GAP_WIDTH   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [LEN_WIDTH-1:0]   frame_len,
  input  logic [COUNT_WIDTH-1:0] frame_count,
  input  logic [GAP_WIDTH-1:0]   gap_cycles,
  input  logic [DATA_WIDTH-1:0]  data_seed,
  input  logic                   bad_frame_en,
  input  logic [COUNT_WIDTH-1:0] bad_frame_index,
  axis_frame_source_if.master    output_axis,
  output logic                   busy,
  output logic                   done,
  output logic [COUNT_WIDTH-1:0] frames_sent
);

  localparam logic [DATA_WIDTH-1:0]  DATA_ONE  = DATA_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0]  DATA_ZERO = {DATA_WIDTH{1'b0}};
  localparam logic [LEN_WIDTH-1:0]   LEN_ONE   = LEN_WIDTH'(1);
  localparam logic [LEN_WIDTH-1:0]   LEN_ZERO  = {LEN_WIDTH{1'b0}};
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE   = COUNT_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] CNT_ZERO  = {COUNT_WIDTH{1'b0}};
  localparam logic [GAP_WIDTH-1:0]   GAP_ZERO  = {GAP_WIDTH{1'b0}};

  logic [1:0]             state_r,  state_s;
  logic [DATA_WIDTH-1:0]  tdata_r,  tdata_s;
  logic                   tvalid_r, tvalid_s;
  logic                   tlast_r,  tlast_s;
  logic                   busy_r,   busy_s;
  logic                   done_r,   done_s;
  logic [COUNT_WIDTH-1:0] frames_r, frames_s;
  logic [LEN_WIDTH-1:0]   beat_r,   beat_s;
  logic [LEN_WIDTH-1:0]   len_m1_r, len_m1_s;
  logic [COUNT_WIDTH-1:0] count_r,  count_s;
  logic [GAP_WIDTH-1:0]   gap_r,    gap_s;
  logic                   gap_load_s;
  logic                   gap_expire_s;
  logic                   cfg_load_s;

  assign cfg_load_s = (state_r == ST_IDLE) && start;

  axis_frame_source_gap_timer #(
    .WIDTH (GAP_WIDTH)
  ) u_gap_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (gap_load_s),
    .load_value (gap_r),
    .expire     (gap_expire_s)
  );

  // Next-state and next-output logic for the frame sequencer.
  always_comb begin
    state_s    = state_r;
    tdata_s    = tdata_r;
    tvalid_s   = tvalid_r;
    tlast_s    = tlast_r;
    busy_s     = busy_r;
    done_s     = 1'b0;
    frames_s   = frames_r;
    beat_s     = beat_r;
    len_m1_s   = len_m1_r;
    count_s    = count_r;
    gap_s      = gap_r;
    gap_load_s = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (start) begin
          // A zero length is promoted to a single-beat frame.
          if (frame_len == LEN_ZERO) begin
            len_m1_s = LEN_ZERO;
          end else begin
            len_m1_s = frame_len - LEN_ONE;
          end
          count_s  = frame_count;
          gap_s    = gap_cycles;
          frames_s = CNT_ZERO;
          beat_s   = LEN_ZERO;
          tdata_s  = data_seed;
          if (frame_count == CNT_ZERO) begin
            state_s  = ST_FINISH;
            tvalid_s = 1'b0;
            tlast_s  = 1'b0;
            busy_s   = 1'b0;
          end else begin
            state_s  = ST_SEND;
            tvalid_s = 1'b1;
            tlast_s  = (len_m1_s == LEN_ZERO);
            busy_s   = 1'b1;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_SEND: begin
        if (tvalid_r && output_axis.tready) begin
          tdata_s = tdata_r + DATA_ONE;
          if (tlast_r) begin
            frames_s = frames_r + CNT_ONE;
            beat_s   = LEN_ZERO;
            if (frames_s == count_r) begin
              state_s  = ST_FINISH;
              tvalid_s = 1'b0;
              tlast_s  = 1'b0;
              busy_s   = 1'b0;
            end else if (gap_r == GAP_ZERO) begin
              state_s = ST_SEND;
              tlast_s = (len_m1_r == LEN_ZERO);
            end else begin
              state_s    = ST_GAP;
              tvalid_s   = 1'b0;
              tlast_s    = 1'b0;
              gap_load_s = 1'b1;
            end
          end else begin
            beat_s  = beat_r + LEN_ONE;
            tlast_s = (beat_s == len_m1_r);
          end
        end else begin
          state_s = ST_SEND;
        end
      end

      ST_GAP: begin
        if (gap_expire_s) begin
          state_s  = ST_SEND;
          tvalid_s = 1'b1;
          tlast_s  = (len_m1_r == LEN_ZERO);
        end else begin
          state_s = ST_GAP;
        end
      end

      ST_FINISH: begin
        done_s  = 1'b1;
        state_s = ST_IDLE;
      end

      default: begin
        state_s  = ST_IDLE;
        tvalid_s = 1'b0;
        tlast_s  = 1'b0;
        busy_s   = 1'b0;
      end
    endcase
  end

  // Sequencer and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      tdata_r  <= DATA_ZERO;
      tvalid_r <= 1'b0;
      tlast_r  <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      frames_r <= CNT_ZERO;
      beat_r   <= LEN_ZERO;
      len_m1_r <= LEN_ZERO;
      count_r  <= CNT_ZERO;
      gap_r    <= GAP_ZERO;
    end else begin
      state_r  <= state_s;
      tdata_r  <= tdata_s;
      tvalid_r <= tvalid_s;
      tlast_r  <= tlast_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
      frames_r <= frames_s;
      beat_r   <= beat_s;
      len_m1_r <= len_m1_s;
      count_r  <= count_s;
      gap_r    <= gap_s;
    end
  end

`ifdef AXIS_FRAME_SOURCE_BAD_FRAME_EN
  logic                   bad_en_r;
  logic [COUNT_WIDTH-1:0] bad_idx_r;
  logic                   bad_en_s;
  logic [COUNT_WIDTH-1:0] bad_idx_s;
  logic                   tuser_s;
  logic                   tuser_r;

  // Bad-frame selection; the start cycle uses the live inputs so frame 0 can be marked.
  always_comb begin
    bad_en_s  = bad_en_r;
    bad_idx_s = bad_idx_r;
    if (cfg_load_s) begin
      bad_en_s  = bad_frame_en;
      bad_idx_s = bad_frame_index;
    end else begin
      bad_en_s  = bad_en_r;
      bad_idx_s = bad_idx_r;
    end
    if (bad_en_s && (bad_idx_s == frames_s) && tlast_s && tvalid_s) begin
      tuser_s = USER_BAD_FRAME;
    end else begin
      tuser_s = 1'b0;
    end
  end

  // Bad-frame configuration and tuser registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      bad_en_r  <= 1'b0;
      bad_idx_r <= CNT_ZERO;
      tuser_r   <= 1'b0;
    end else begin
      bad_en_r  <= bad_en_s;
      bad_idx_r <= bad_idx_s;
      tuser_r   <= tuser_s;
    end
  end

  assign output_axis.tuser = tuser_r;
`else
  logic unused_bad_cfg;
  assign unused_bad_cfg    = ^{bad_frame_en, bad_frame_index, cfg_load_s};
  assign output_axis.tuser = 1'b0;
`endif

  assign output_axis.tdata  = tdata_r;
  assign output_axis.tvalid = tvalid_r;
  assign output_axis.tlast  = tlast_r;
  assign busy               = busy_r;
  assign done               = done_r;
  assign frames_sent        = frames_r;

endmodule

// File: tb/tb_axis_frame_source.sv
// Self-checking bench for axis_frame_source: directed and randomized runs
// compared against a beat-list reference model.
module tb_axis_frame_source;

  localparam int DW = 8;
  localparam int LW = 8;
  localparam int CW = 8;
  localparam int GW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [LW-1:0] frame_len;
  logic [CW-1:0] frame_count;
  logic [GW-1:0] gap_cycles;
  logic [DW-1:0] data_seed;
  logic          bad_frame_en;
  logic [CW-1:0] bad_frame_index;
  logic          busy;
  logic          done;
  logic [CW-1:0] frames_sent;

  axis_frame_source_if #(.DATA_WIDTH(DW)) axis ();

  axis_frame_source #(
    .DATA_WIDTH  (DW),
    .LEN_WIDTH   (LW),
    .COUNT_WIDTH (CW),
    .GAP_WIDTH   (GW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .frame_len       (frame_len),
    .frame_count     (frame_count),
    .gap_cycles      (gap_cycles),
    .data_seed       (data_seed),
    .bad_frame_en    (bad_frame_en),
    .bad_frame_index (bad_frame_index),
    .output_axis     (axis),
    .busy            (busy),
    .done            (done),
    .frames_sent     (frames_sent)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] q_data[$];
  logic          q_last[$];
  logic          q_user[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic ready_of(input int mode, input int c);
    logic [3:0] pat;
    pat = 4'b1001;
    case (mode)
      0:       return 1'b1;
      1:       return pat[c % 4];
      default: return ($urandom_range(0, 3) != 0);
    endcase
  endfunction

  // Reference model: the full list of beats the run must deliver, in order.
  task automatic build_model(input int len, input int count, input logic [DW-1:0] seed,
                             input logic en, input int idx);
    int l;
    logic [DW-1:0] d;
    logic u;
    l = (len == 0) ? 1 : len;
    d = seed;
    q_data.delete();
    q_last.delete();
    q_user.delete();
    for (int f = 0; f < count; f++) begin
      for (int b = 0; b < l; b++) begin
`ifdef AXIS_FRAME_SOURCE_BAD_FRAME_EN
        u = en && (f == idx) && (b == l - 1);
`else
        u = 1'b0;
`endif
        q_data.push_back(d);
        q_last.push_back(b == l - 1);
        q_user.push_back(u);
        d = d + 8'd1;
      end
    end
  endtask

  task automatic run(input int len, input int count, input int gap, input logic [DW-1:0] seed,
                     input logic en, input int idx, input int mode, input bit noisy, input string name);
    int gap_left;
    int frames_done;
    int cyc;
    int phase;
    int budget;
    bit finished;
    gap_left    = 0;
    frames_done = 0;
    cyc         = 0;
    phase       = 0;
    finished    = 1'b0;
    build_model(len, count, seed, en, idx);
    budget = 8 * (q_data.size() + 1) + count * gap + 20;

    @(posedge clk); #1;
    frame_len       = LW'(len);
    frame_count     = CW'(count);
    gap_cycles      = GW'(gap);
    data_seed       = seed;
    bad_frame_en    = en;
    bad_frame_index = CW'(idx);
    start           = 1'b1;
    axis.tready     = ready_of(mode, 0);
    @(posedge clk); #1;
    start           = 1'b0;
    frame_len       = LW'($urandom);
    frame_count     = CW'($urandom);
    gap_cycles      = GW'($urandom);
    data_seed       = DW'($urandom);
    bad_frame_en    = 1'($urandom);
    bad_frame_index = CW'($urandom);

    while (!finished && cyc < budget) begin
      @(negedge clk);
      if (q_data.size() != 0) begin
        check({name, " tvalid"}, 32'(axis.tvalid), 32'(gap_left == 0));
        check({name, " busy"}, 32'(busy), 32'd1);
        check({name, " done_low"}, 32'(done), 32'd0);
        check({name, " frames_sent"}, 32'(frames_sent), 32'(frames_done));
        if (gap_left == 0) begin
          check({name, " tdata"}, 32'(axis.tdata), 32'(q_data[0]));
          check({name, " tlast"}, 32'(axis.tlast), 32'(q_last[0]));
          check({name, " tuser"}, 32'(axis.tuser), 32'(q_user[0]));
          if (axis.tready) begin
            if (q_last[0]) begin
              frames_done++;
              gap_left = (q_data.size() > 1) ? gap : 0;
            end
            void'(q_data.pop_front());
            void'(q_last.pop_front());
            void'(q_user.pop_front());
          end
        end else begin
          gap_left--;
        end
      end else begin
        check({name, " end_tvalid"}, 32'(axis.tvalid), 32'd0);
        check({name, " end_busy"}, 32'(busy), 32'd0);
        check({name, " end_frames"}, 32'(frames_sent), 32'(count));
        check({name, " done"}, 32'(done), 32'(phase == 1));
        if (phase == 1) finished = 1'b1;
        phase++;
      end
      @(posedge clk); #1;
      cyc++;
      axis.tready = ready_of(mode, cyc);
      start = (noisy && q_data.size() != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    start = 1'b0;
    check({name, " completed"}, 32'(finished), 32'd1);
    @(negedge clk);
    check({name, " done_pulse_end"}, 32'(done), 32'd0);
  endtask

  initial begin
    rst             = 1'b1;
    start           = 1'b0;
    frame_len       = '0;
    frame_count     = '0;
    gap_cycles      = '0;
    data_seed       = '0;
    bad_frame_en    = 1'b0;
    bad_frame_index = '0;
    axis.tready     = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset tdata", 32'(axis.tdata), 32'd0);
    check("reset tvalid", 32'(axis.tvalid), 32'd0);
    check("reset tlast", 32'(axis.tlast), 32'd0);
    check("reset tuser", 32'(axis.tuser), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset frames_sent", 32'(frames_sent), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    run(3, 2, 0, 8'h01, 1'b0, 0, 0, 1'b0, "basic");
    run(4, 1, 0, 8'h10, 1'b0, 0, 1, 1'b0, "backpressure");
    run(2, 3, 3, 8'hFE, 1'b0, 0, 0, 1'b0, "gap_wrap");
    run(5, 0, 2, 8'h55, 1'b0, 0, 0, 1'b0, "count0");
    run(0, 4, 1, 8'hA0, 1'b0, 0, 2, 1'b0, "len0");
    run(3, 3, 0, 8'h20, 1'b1, 1, 0, 1'b0, "bad_frame");
    run(1, 2, 2, 8'h70, 1'b1, 0, 2, 1'b0, "bad_frame0");

    // Reset in the middle of a 4-beat frame.
    @(posedge clk); #1;
    frame_len   = 8'd4;
    frame_count = 8'd2;
    gap_cycles  = 4'd0;
    data_seed   = 8'h30;
    start       = 1'b1;
    axis.tready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("midrst beat0", 32'(axis.tdata), 32'h30);
    @(posedge clk); #1;
    @(negedge clk);
    check("midrst beat1", 32'(axis.tdata), 32'h31);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst tvalid", 32'(axis.tvalid), 32'd0);
    check("midrst tlast", 32'(axis.tlast), 32'd0);
    check("midrst frames_sent", 32'(frames_sent), 32'd0);
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst done", 32'(done), 32'd0);
    run(4, 2, 0, 8'h30, 1'b0, 0, 0, 1'b0, "after_rst");

    for (int r = 0; r < 8; r++) begin
      run($urandom_range(0, 6), $urandom_range(0, 5), $urandom_range(0, 4), DW'($urandom),
          1'($urandom_range(0, 1)), $urandom_range(0, 4), 2, 1'b1, "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
